fpu_wb_arbiter: RTL

- Shares the single FPU `output_interface` packer among N_REQ execution units (add, mul, div, ...).
- Each unit offers {mode, int, exp, sign} via valid/ready; the arbiter grants one per cycle round-robin and drives the packer.
- The packed REG_SIZE word is captured in a one-entry output register and handed to register-file writeback with valid/ready and a requester tag.
- Sits between the FPU execution units and the writeback port.

---
 rtl/fpu_wb_arbiter_pkg.sv | 37 +++
 rtl/fpu_wb_arbiter_rr_arbiter.sv | 46 ++++
 rtl/fpu_wb_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fpu_wb_arbiter_pkg.sv
// Shared definitions for the FPU writeback arbiter: mode encodings, packer
// field widths, writeback FSM states and the output_interface packer.
package fpu_wb_arbiter_pkg;

    localparam logic S_MODE = 1'b0;
    localparam logic D_MODE = 1'b1;

    localparam int REG_SIZE                = 64;
    localparam int OUTPUT_INTERFACE_INT_IN = 64;
    localparam int OUTPUT_INTERFACE_EXP_IN = 11;
    localparam int FPU_WB_TAG_W            = 2;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wbState_e;

    // Packs sign/exponent/mantissa into an IEEE-754 register image.
    // Double: {sign, exp[10:0], int[51:0]}.
    // Single: upper 32 bits zero, low word {sign, exp[7:0], int[22:0]}.
    function automatic logic [REG_SIZE-1:0] output_interface(
        input logic                               mode,
        input logic [OUTPUT_INTERFACE_INT_IN-1:0] intVal,
        input logic [OUTPUT_INTERFACE_EXP_IN-1:0] expVal,
        input logic                               sign
    );
        logic [REG_SIZE-1:0] word;
        word = '0;
        if (mode == D_MODE) begin
            word = {sign, expVal, intVal[51:0]};
        end else begin
            word = {32'h0000_0000, sign, expVal[7:0], intVal[22:0]};
        end
        return word;
    endfunction

endpackage

// File: rtl/fpu_wb_arbiter_rr_arbiter.sv
// Round-robin grant encoder: picks the first requesting index at or after
// rrPtr, wrapping modulo N_REQ. The index never reaches N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int TAG_W = 2
) (
    input  logic [N_REQ-1:0] reqVec,
    input  logic [TAG_W-1:0] rrPtr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] grantIdx,
    output logic             grantVld
);

    logic [TAG_W:0] cand_s;
    logic           found_s;

    // Scan requesters starting at the pointer and build one-hot grant.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, rrPtr} + (TAG_W+1)'(k);
            if (cand_s >= (TAG_W+1)'(N_REQ)) begin
                cand_s = cand_s - (TAG_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && (cand_s < (TAG_W+1)'(N_REQ)) && reqVec[cand_s[TAG_W-1:0]]) begin
                found_s  = 1'b1;
                grantIdx = cand_s[TAG_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
        grantVld = found_s & enable;
        if (grantVld) begin
            grant[grantIdx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Shares the FPU output packer among N_REQ execution units. One winner per
// cycle (round-robin) is packed into a one-entry output register that feeds
// register-file writeback through a valid/ready handshake.
module fpu_wb_arbiter
    import fpu_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int INT_W = OUTPUT_INTERFACE_INT_IN,
    parameter int EXP_W = OUTPUT_INTERFACE_EXP_IN,
    parameter int REG_W = REG_SIZE,
    parameter int TAG_W = FPU_WB_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_mode,
    input  logic [N_REQ*INT_W-1:0] req_int,
    input  logic [N_REQ*EXP_W-1:0] req_exp,
    input  logic [N_REQ-1:0]       req_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_W-1:0]       out_data,
    output logic                   out_mode,
    output logic [TAG_W-1:0]       out_tag,
    output logic [15:0]            busy_cnt
);

    wbState_e         state_r;
    wbState_e         nextState_s;
    logic [TAG_W-1:0] rrPtr_r;
    logic [REG_W-1:0] data_r;
    logic             mode_r;
    logic [TAG_W-1:0] tag_r;
    logic [15:0]      busy_r;

    logic             canAccept_s;
    logic             arbEn_s;
    logic [N_REQ-1:0] grant_s;
    logic [TAG_W-1:0] grantIdx_s;
    logic             fire_s;
    logic             winMode_s;
    logic             winSign_s;
    logic [INT_W-1:0] winInt_s;
    logic [EXP_W-1:0] winExp_s;
    logic [REG_W-1:0] packed_s;

    // Ready is suppressed while reset is held so no unit sees a phantom accept.
    assign canAccept_s = (state_r == WB_EMPTY) | out_ready;
    assign arbEn_s     = canAccept_s & rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_rr (
        .reqVec   (req_valid),
        .rrPtr    (rrPtr_r),
        .enable   (arbEn_s),
        .grant    (grant_s),
        .grantIdx (grantIdx_s),
        .grantVld (fire_s)
    );

    assign req_ready = grant_s;

    // AND-OR mux of the winning unit's payload into the packer.
    always_comb begin
        winMode_s = 1'b0;
        winSign_s = 1'b0;
        winInt_s  = '0;
        winExp_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            winMode_s = winMode_s | (req_mode[i] & (grantIdx_s == TAG_W'(i)));
            winSign_s = winSign_s | (req_sign[i] & (grantIdx_s == TAG_W'(i)));
            winInt_s  = winInt_s | (req_int[i*INT_W +: INT_W] & {INT_W{grantIdx_s == TAG_W'(i)}});
            winExp_s  = winExp_s | (req_exp[i*EXP_W +: EXP_W] & {EXP_W{grantIdx_s == TAG_W'(i)}});
        end
    end

    assign packed_s = output_interface(winMode_s, winInt_s, winExp_s, winSign_s);

    // Output-holding FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WB_EMPTY;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next state: a grant always fills; a retire with no grant empties.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            WB_EMPTY: begin
                if (fire_s) nextState_s = WB_FULL;
                else        nextState_s = WB_EMPTY;
            end
            WB_FULL: begin
                if (fire_s)         nextState_s = WB_FULL;
                else if (out_ready) nextState_s = WB_EMPTY;
                else                nextState_s = WB_FULL;
            end
            default: nextState_s = WB_EMPTY;
        endcase
    end

    // Capture the packed winner and advance the round-robin pointer on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            mode_r  <= S_MODE;
            tag_r   <= '0;
            rrPtr_r <= '0;
        end else if (fire_s) begin
            data_r  <= packed_s;
            mode_r  <= winMode_s;
            tag_r   <= grantIdx_s;
            rrPtr_r <= (grantIdx_s == TAG_W'(N_REQ-1)) ? '0 : grantIdx_s + TAG_W'(1);
        end else begin
            data_r  <= data_r;
            mode_r  <= mode_r;
            tag_r   <= tag_r;
            rrPtr_r <= rrPtr_r;
        end
    end

    // Saturating count of cycles where a unit waits behind a stalled output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 16'h0000;
        end else if ((|req_valid) && !canAccept_s && (busy_r != 16'hFFFF)) begin
            busy_r <= busy_r + 16'h0001;
        end else begin
            busy_r <= busy_r;
        end
    end

    assign out_valid = (state_r == WB_FULL);
    assign out_data  = data_r;
    assign out_mode  = mode_r;
    assign out_tag   = tag_r;
    assign busy_cnt  = busy_r;

endmodule
